// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: datapath width, major opcodes, fetch FSM encoding, fetch buffer entry.
// No logic, so no latency of its own.
// No flow control of its own; consumers apply their own backpressure.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Raw encodings kept as plain constants so legacy code can compare against bits.
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  typedef enum logic [0:0] {
    FETCH = ST_FETCH,
    DRAIN = ST_DRAIN
  } fetch_state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instructions between memory and decode.
// Head is registered storage: data pushed on an edge is visible after that edge.
// Push while full is dropped unless a pop happens in the same cycle; flush wins over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; a flush empties the queue in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word fetches, buffers in-order responses, presents them to decode.
// Two cycles from request to id_valid with zero-wait memory; one cycle from rvalid to id_valid.
// Requests are credit limited (in flight + buffered <= DEPTH); decode stalls hold the id_* outputs.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight_left;
  logic [CNT_W-1:0] discard_left;
  logic             fifo_empty;
  logic             credit_ok;
  logic             grant;
  logic             resp;
  logic             drop;
  logic             pop;
  logic [XLEN-1:0]  resp_pc;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic             unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  // A response belongs to the live stream while requests are in flight; while
  // discarding, every response is one issued before the last redirect.
  assign resp = imem_rvalid && (inflight != '0);
  assign drop = imem_rvalid && (discard != '0);
  assign pop  = id_valid && id_ready;

  // A pop in the same cycle frees its slot, which sustains one fetch per cycle at DEPTH=2
  // without letting in flight + buffered exceed DEPTH after the edge.
  assign credit_ok = (int'(inflight) + int'(fifo_count) - int'(pop)) < DEPTH;

  assign imem_req  = !rst && (state == FETCH) && !redirect_valid && credit_ok;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  // Responses return in order, so the oldest outstanding address sits inflight words back.
  assign resp_pc          = fetch_pc - (XLEN'(inflight) << 2);
  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = imem_rdata;

  assign inflight_left = inflight - CNT_W'(resp);
  assign discard_left  = discard - CNT_W'(drop);

  // Fetch address, outstanding-request counters and FETCH/DRAIN sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= '0;
      if (state == FETCH) begin
        discard <= inflight_left;
        state   <= (inflight_left != '0) ? DRAIN : FETCH;
      end else begin
        // Already draining: outstanding count is unaffected by the new target.
        discard <= discard_left;
        state   <= (discard_left != '0) ? DRAIN : FETCH;
      end
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      inflight <= inflight + CNT_W'(grant) - CNT_W'(resp);
      discard  <= discard_left;
      if (state == DRAIN && discard_left == '0) state <= FETCH;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp && !redirect_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign id_valid  = !fifo_empty;
  assign id_pc     = head_entry.pc;
  assign id_instr  = head_entry.instr;
  assign id_opcode = head_entry.instr[6:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter: DEPTH, 2, instruction buffer entries; also the cap on in-flight requests plus buffered entries.
REQ-003 SHALL have port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: imem_req  out  1  fetch request to instruction memory.
REQ-006 SHALL have port: imem_addr  out  32  fetch address; word-aligned.
REQ-007 SHALL have port: imem_gnt  in  1  request accepted when imem_req and imem_gnt are both high.
REQ-008 SHALL have port: imem_rvalid  in  1  read data valid; in order; at least 1 cycle after grant.
REQ-009 SHALL have port: imem_rdata  in  32  instruction word.
REQ-010 SHALL have port: redirect_valid  in  1  branch taken or redirect; flushes the unit.
REQ-011 SHALL have port: redirect_pc  in  32  new fetch target.
REQ-012 SHALL have port: id_valid  out  1  instruction presented to decode.
REQ-013 SHALL have port: id_ready  in  1  decode accepts the instruction.
REQ-014 SHALL have port: id_instr  out  32  instruction word.
REQ-015 SHALL have port: id_pc  out  32  address of id_instr.
REQ-016 SHALL have port: id_opcode  out  7  id_instr[6:0]; feeds the control unit directly.

Function
REQ-017 SHALL implement FSM states FETCH and DRAIN; FETCH is the state after reset.
REQ-018 In FETCH, imem_req SHALL equal (inflight + count < DEPTH) and not redirect_valid; imem_addr SHALL equal fetch_pc.
REQ-019 On each grant, fetch_pc SHALL increase by 4 (modulo 2^32) and inflight SHALL increase by 1.
REQ-020 On each accepted imem_rvalid, the unit SHALL push {pc, rdata} into the buffer and decrement inflight; pc is the address granted for that response.
REQ-021 Latency SHALL be as follows: id_valid rises in the cycle after rvalid; no combinational path from rvalid to the id_* outputs.
REQ-022 id_valid SHALL equal buffer-not-empty; a pop SHALL occur on id_valid and id_ready; outputs SHALL hold stable while id_valid is high and id_ready is low.
REQ-023 Buffer full plus a simultaneous pop SHALL be legal; overflow SHALL be impossible by the credit rule in REQ-018.
REQ-024 On redirect_valid, the unit SHALL do the following in the same edge: flush the buffer, set fetch_pc to {redirect_pc[31:2], 2'b00}, set discard to inflight (counting any rvalid in that same cycle), and set inflight to 0.
REQ-025 Next state after a redirect SHALL be DRAIN if discard > 0, otherwise FETCH.
REQ-026 In DRAIN, imem_req SHALL be 0; each rvalid SHALL decrement discard and be dropped; the FSM SHALL move to FETCH when discard reaches 0.
REQ-027 A redirect during DRAIN SHALL update fetch_pc only; discard SHALL be unchanged.
REQ-028 A redirect with a simultaneous pop SHALL have the flush win; the pop is still taken by decode.
REQ-029 An imem_rvalid with inflight = 0 and discard = 0 SHALL be ignored.

Reset
REQ-030 While rst is high, the following SHALL hold: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_opcode=0, fetch_pc=RESET_PC, inflight=0, discard=0, buffer empty, state FETCH.
REQ-031 The first request SHALL be issued in the first cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL discard all in-flight and buffered instructions.

Structure
REQ-033 Shared package rv32_pkg SHALL hold: XLEN=32, opcode constants (OP_R 0110011, OP_IMM 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011), and the fetch state enum.
REQ-034 The buffer SHALL be a sub-module fetch_fifo: synchronous, DEPTH-parameterised, with its own count output.

Verification
REQ-035 Zero-wait memory with id_ready=1 -> id_pc sequence 0,4,8,...; steady state of 1 instruction per cycle after a 2-cycle start latency.
REQ-036 id_ready=0 for 10 cycles -> at most 2 instructions buffered, imem_req low when full, id_* stable; on release, no instruction lost or duplicated.
REQ-037 Redirect to 0x100 with 2 requests in flight -> both responses dropped, DRAIN for 2 rvalids, next id_pc=0x100.
REQ-038 redirect_pc=0x203 -> imem_addr=0x200.
REQ-039 Redirect in the same cycle as rvalid and id pop -> buffer empty next cycle, the rvalid data is never presented.
REQ-040 Assert rst mid-stream -> outputs zero immediately; first imem_addr after release is RESET_PC.
